cam_fill_ctrl: RTL
==================

Name: cam_fill_ctrl

Overview:
Front-end controller that owns the lookup and write sides of the tag CAM cache.
- Accepts tag lookup requests and presents them to the CAM.
- On a hit, returns the CAM data.
- On a miss, fetches the word from backing memory, writes it into a round-robin victim slot, then returns the fetched data.
- Also provides a flush sequence that invalidates every CAM entry.

Parameters:
WORDS, 8, number of CAM entries
BITS, 8, data word width
ADDR_LEFT, $clog2(WORDS)-1, MSB of CAM slot address
TAG_SZ, 8, tag width; also the backing-memory address width
CNT_W, 16, width of hit/miss counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  lookup request valid
req_ready  output  1  controller can accept a request
req_tag  input  TAG_SZ  tag to look up
resp_valid  output  1  response valid
resp_ready  input  1  consumer accepts response
resp_data  output  BITS  returned data
resp_hit  output  1  1 = served from CAM, 0 = filled from memory
flush  input  1  pulse: invalidate all entries
flush_done  output  1  one-cycle pulse when flush completes
cam_read  output  1  CAM lookup enable
cam_check_tag  output  TAG_SZ  tag driven to CAM
cam_data  input  BITS  CAM read data
cam_found_it  input  1  CAM hit indication
cam_write_  output  1  CAM write strobe, active low
cam_w_addr  output  ADDR_LEFT+1  CAM write slot
cam_wdata  output  BITS  CAM write data
cam_new_tag  output  TAG_SZ  CAM write tag
cam_new_valid  output  1  CAM write valid bit
mem_req  output  1  backing-memory read request
mem_addr  output  TAG_SZ  backing-memory address (= tag)
mem_ack  input  1  memory data valid, one-cycle pulse
mem_rdata  input  BITS  memory read data
hit_cnt  output  CNT_W  saturating hit count
miss_cnt  output  CNT_W  saturating miss count

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - State IDLE; victim pointer 0; flush_pending 0.
  - req_ready=1, resp_valid=0, resp_data=0, resp_hit=0, flush_done=0.
  - cam_read=0, cam_write_=1, cam_new_valid=0, cam_w_addr/cam_wdata/cam_new_tag/cam_check_tag=0.
  - mem_req=0, mem_addr=0, hit_cnt=0, miss_cnt=0.
- The CAM is not cleared by this block.
- States: IDLE, LOOKUP, MEM_WAIT, FILL, RESP, FLUSH.
- IDLE:
  - req_ready=1.
  - If flush or flush_pending: go to FLUSH, flush takes priority, req_ready=0 that cycle.
  - Else if req_valid: register req_tag, go to LOOKUP.
- LOOKUP (1 cycle):
  - cam_read=1, cam_check_tag=registered tag.
  - cam_found_it/cam_data are sampled at the end of this cycle; the CAM lookup is combinational.
  - Hit: resp_data=cam_data, resp_hit=1, hit_cnt++, go to RESP.
  - Miss: miss_cnt++, go to MEM_WAIT.
- MEM_WAIT:
  - mem_req=1, mem_addr=tag, held until mem_ack.
  - On mem_ack: capture mem_rdata, go to FILL.
  - mem_ack in any other state is ignored.
- FILL (1 cycle):
  - cam_write_=0, cam_w_addr=victim pointer, cam_wdata=captured data, cam_new_tag=tag, cam_new_valid=1.
  - Pointer increments, wrapping WORDS-1 -> 0.
  - resp_data=captured data, resp_hit=0, go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_hit are stable until resp_valid&resp_ready.
  - On the handshake, return to IDLE.
- Latency: request accepted at cycle 0, so a hit has resp_valid at cycle 2. A miss has resp_valid 2 cycles after the mem_ack cycle.
- FLUSH:
  - Runs WORDS cycles. Each cycle drives cam_write_=0, cam_new_valid=0, cam_new_tag=0, cam_wdata=0, cam_w_addr=0..WORDS-1 in order.
  - After the last cycle: victim pointer=0, flush_pending=0, flush_done=1 for one cycle, return to IDLE.
- flush outside IDLE: sets flush_pending. The in-flight request completes normally, then FLUSH runs.
- Counters: saturate at all-ones, no wrap.
- cam_write_ is low only in FILL and FLUSH. cam_read is high only in LOOKUP. Both are never active in the same cycle.
- Reset asserted mid-operation: immediate return to reset values. Any outstanding memory request is abandoned, and a later mem_ack is ignored.

Test Plan:
- After reset, req_tag=0x3C against an empty CAM (cam_found_it=0) -> mem_req=1, mem_addr=0x3C. Then mem_ack with mem_rdata=0xA5 -> one FILL cycle with cam_w_addr=0, cam_new_tag=0x3C, cam_wdata=0xA5, cam_new_valid=1. Then resp_data=0xA5, resp_hit=0, miss_cnt=1.
- Hit: cam_found_it=1, cam_data=0x5A -> resp_valid 2 cycles after acceptance, resp_hit=1, hit_cnt=1, mem_req never asserted.
- Nine misses with WORDS=8 -> FILL slots 0,1,...,7,0.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0, no new lookups.
- flush pulsed during MEM_WAIT -> the request completes first. Then 8 FLUSH write cycles at addresses 0..7 with cam_new_valid=0, flush_done pulse, and the next miss fills slot 0.
- rst asserted during MEM_WAIT, then a late mem_ack -> outputs return to reset values and the ack produces no FILL.

Source files
------------

// File: rtl/cam_fill_ctrl_if.sv
// Bundle of request/response, CAM and backing-memory signals around cam_fill_ctrl.
// master = controller side, slave = environment (requester, CAM, memory).
interface cam_fill_ctrl_if #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned BITS   = 8,
    parameter int unsigned TAG_SZ = 8,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned ADDR_LEFT = $clog2(WORDS) - 1;

    logic                 req_valid;
    logic                 req_ready;
    logic [TAG_SZ-1:0]    req_tag;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [BITS-1:0]      resp_data;
    logic                 resp_hit;
    logic                 flush;
    logic                 flush_done;
    logic                 cam_read;
    logic [TAG_SZ-1:0]    cam_check_tag;
    logic [BITS-1:0]      cam_data;
    logic                 cam_found_it;
    logic                 cam_write_;
    logic [ADDR_LEFT:0]   cam_w_addr;
    logic [BITS-1:0]      cam_wdata;
    logic [TAG_SZ-1:0]    cam_new_tag;
    logic                 cam_new_valid;
    logic                 mem_req;
    logic [TAG_SZ-1:0]    mem_addr;
    logic                 mem_ack;
    logic [BITS-1:0]      mem_rdata;
    logic [CNT_W-1:0]     hit_cnt;
    logic [CNT_W-1:0]     miss_cnt;

    modport master (
        input  req_valid, req_tag, resp_ready, flush,
               cam_data, cam_found_it, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_hit, flush_done,
               cam_read, cam_check_tag, cam_write_, cam_w_addr, cam_wdata,
               cam_new_tag, cam_new_valid, mem_req, mem_addr, hit_cnt, miss_cnt
    );

    modport slave (
        output req_valid, req_tag, resp_ready, flush,
               cam_data, cam_found_it, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_hit, flush_done,
               cam_read, cam_check_tag, cam_write_, cam_w_addr, cam_wdata,
               cam_new_tag, cam_new_valid, mem_req, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cam_fill_ctrl.sv
// Lookup/fill controller for the tag CAM: hit returns CAM data, miss fetches from
// memory and fills a round-robin victim slot, flush invalidates every entry.
module cam_fill_ctrl #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned BITS   = 8,
    parameter int unsigned TAG_SZ = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    cam_fill_ctrl_if.master bus
);
    localparam int unsigned ADDR_LEFT = $clog2(WORDS) - 1;
    localparam int unsigned AW        = ADDR_LEFT + 1;
    localparam logic [AW-1:0] LAST_SLOT = AW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_WAIT,
        S_FILL,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_victim;
    logic              r_flush_pending;
    logic [TAG_SZ-1:0] r_tag;
    logic [BITS-1:0]   r_mem_data;

    logic              r_ready;
    logic              r_resp_valid;
    logic [BITS-1:0]   r_resp_data;
    logic              r_resp_hit;
    logic              r_flush_done;
    logic              r_cam_read;
    logic [TAG_SZ-1:0] r_cam_check_tag;
    logic              r_cam_write_;
    logic [AW-1:0]     r_cam_w_addr;
    logic [BITS-1:0]   r_cam_wdata;
    logic [TAG_SZ-1:0] r_cam_new_tag;
    logic              r_cam_new_valid;
    logic              r_mem_req;
    logic [TAG_SZ-1:0] r_mem_addr;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic              w_flush_go;
    logic              w_flush_defer;

    assign w_flush_go    = (r_state == S_IDLE) && (bus.flush || r_flush_pending);
    assign w_flush_defer = bus.flush && (r_state != S_IDLE) && (r_state != S_FLUSH);

    // A flush in the same cycle as an idle request wins, so the request is held off.
    assign bus.req_ready     = r_ready & ~bus.flush;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_hit      = r_resp_hit;
    assign bus.flush_done    = r_flush_done;
    assign bus.cam_read      = r_cam_read;
    assign bus.cam_check_tag = r_cam_check_tag;
    assign bus.cam_write_    = r_cam_write_;
    assign bus.cam_w_addr    = r_cam_w_addr;
    assign bus.cam_wdata     = r_cam_wdata;
    assign bus.cam_new_tag   = r_cam_new_tag;
    assign bus.cam_new_valid = r_cam_new_valid;
    assign bus.mem_req       = r_mem_req;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.hit_cnt       = r_hit_cnt;
    assign bus.miss_cnt      = r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_victim        <= '0;
            r_flush_pending <= 1'b0;
            r_tag           <= '0;
            r_mem_data      <= '0;
            r_ready         <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= '0;
            r_resp_hit      <= 1'b0;
            r_flush_done    <= 1'b0;
            r_cam_read      <= 1'b0;
            r_cam_check_tag <= '0;
            r_cam_write_    <= 1'b1;
            r_cam_w_addr    <= '0;
            r_cam_wdata     <= '0;
            r_cam_new_tag   <= '0;
            r_cam_new_valid <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_hit_cnt       <= '0;
            r_miss_cnt      <= '0;
        end else begin
            r_flush_done <= 1'b0;
            if (w_flush_defer) begin
                r_flush_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_flush_go) begin
                        r_state         <= S_FLUSH;
                        r_ready         <= 1'b0;
                        r_cam_write_    <= 1'b0;
                        r_cam_new_valid <= 1'b0;
                        r_cam_new_tag   <= '0;
                        r_cam_wdata     <= '0;
                        r_cam_w_addr    <= '0;
                    end else if (bus.req_valid && r_ready) begin
                        r_state         <= S_LOOKUP;
                        r_ready         <= 1'b0;
                        r_tag           <= bus.req_tag;
                        r_cam_check_tag <= bus.req_tag;
                        r_cam_read      <= 1'b1;
                    end
                end

                // CAM answers combinationally within the lookup cycle.
                S_LOOKUP: begin
                    r_cam_read <= 1'b0;
                    if (bus.cam_found_it) begin
                        r_state      <= S_RESP;
                        r_resp_data  <= bus.cam_data;
                        r_resp_hit   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        if (r_hit_cnt != '1) begin
                            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state    <= S_MEM_WAIT;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_tag;
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                    end
                end

                S_MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        r_state         <= S_FILL;
                        r_mem_req       <= 1'b0;
                        r_mem_data      <= bus.mem_rdata;
                        r_cam_write_    <= 1'b0;
                        r_cam_w_addr    <= r_victim;
                        r_cam_wdata     <= bus.mem_rdata;
                        r_cam_new_tag   <= r_tag;
                        r_cam_new_valid <= 1'b1;
                    end
                end

                S_FILL: begin
                    r_state         <= S_RESP;
                    r_cam_write_    <= 1'b1;
                    r_cam_new_valid <= 1'b0;
                    r_resp_data     <= r_mem_data;
                    r_resp_hit      <= 1'b0;
                    r_resp_valid    <= 1'b1;
                    r_victim        <= (r_victim == LAST_SLOT) ? '0 : r_victim + AW'(1);
                end

                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_ready      <= ~(r_flush_pending | bus.flush);
                    end
                end

                // One invalidating write per slot, addresses ascending.
                S_FLUSH: begin
                    if (r_cam_w_addr == LAST_SLOT) begin
                        r_state         <= S_IDLE;
                        r_cam_write_    <= 1'b1;
                        r_cam_w_addr    <= '0;
                        r_victim        <= '0;
                        r_flush_pending <= 1'b0;
                        r_flush_done    <= 1'b1;
                        r_ready         <= 1'b1;
                    end else begin
                        r_cam_w_addr <= r_cam_w_addr + AW'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
